// File: rtl/cfi_lp_checker_if.sv
// Commit-port and violation-record bundle between the retire stage and the landing-pad checker.
// Commit side is valid-only; violation side is a valid/ready handshake.
interface cfi_lp_checker_if #(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned VLEN          = 64
);
    logic [NrCommitPorts-1:0]           commit_valid_i;
    logic [NrCommitPorts-1:0][31:0]     commit_instr_i;
    logic [NrCommitPorts-1:0]           commit_compressed_i;
    logic [NrCommitPorts-1:0][VLEN-1:0] commit_pc_i;

    logic            viol_valid_o;
    logic            viol_ready_i;
    logic [VLEN-1:0] viol_pc_o;
    logic [1:0]      viol_cause_o;

    modport master (
        output commit_valid_i, commit_instr_i, commit_compressed_i, commit_pc_i,
        output viol_ready_i,
        input  viol_valid_o, viol_pc_o, viol_cause_o
    );

    modport slave (
        input  commit_valid_i, commit_instr_i, commit_compressed_i, commit_pc_i,
        input  viol_ready_i,
        output viol_valid_o, viol_pc_o, viol_cause_o
    );
endinterface

// File: rtl/cfi_lp_checker.sv
// Forward-edge CFI landing-pad checker: scans committed instructions in port order and queues violations.
// Records appear one cycle after commit; a full queue drops later records and sets the sticky overflow flag.
module cfi_lp_checker #(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned VLEN          = 64,
    parameter int unsigned ViolFifoDepth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               flush_i,
    cfi_lp_checker_if.slave    bus,
    output logic [24:0]        label_o,
    output logic               viol_overflow_o
);
    localparam int unsigned PW = $clog2(ViolFifoDepth);
    localparam int unsigned CW = PW + 1;

    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpJalr = 7'b1100111;

    typedef enum logic [1:0] {IDLE, EXPECT_LP, CHECKING} state_e;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [1:0]      cause;
    } viol_rec_t;

    state_e          state_q, state_d;
    logic [24:0]     label_q, label_d;
    viol_rec_t       mem_q [ViolFifoDepth];
    viol_rec_t       mem_d [ViolFifoDepth];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic [NrCommitPorts-1:0]      is_jmp, is_lpsll, is_lpcll, is_sml, is_cml, is_sul, is_cul;
    logic [NrCommitPorts-1:0][8:0] lbl9;
    logic [NrCommitPorts-1:0][7:0] lbl8;

    function automatic logic is_ind_jump(input logic [31:0] ins, input logic c);
        logic jalr, jalr_ret, cj, cj_ret;
        jalr     = !c && (ins[6:0] == OpJalr) && (ins[14:12] == 3'b000);
        jalr_ret = (ins[11:7] == 5'd0) && (ins[19:15] == 5'd1 || ins[19:15] == 5'd5)
                   && (ins[31:20] == 12'd0);
        cj       = c && (ins[1:0] == 2'b10) && (ins[15:13] == 3'b100)
                   && (ins[11:7] != 5'd0) && (ins[6:2] == 5'd0);
        // only the non-linking C.JR form can be a return
        cj_ret   = !ins[12] && (ins[11:7] == 5'd1 || ins[11:7] == 5'd5);
        return (jalr && !jalr_ret) || (cj && !cj_ret);
    endfunction

    for (genvar k = 0; k < NrCommitPorts; k++) begin : g_dec
        logic [31:0] ins;
        logic        base;
        assign ins  = bus.commit_instr_i[k];
        assign base = !bus.commit_compressed_i[k] && (ins[6:0] == OpImm)
                      && (ins[14:12] == 3'b100) && (ins[11:7] == 5'd0);
        assign is_lpsll[k] = base && (ins[31:24] == 8'b1000_0010);
        assign is_lpcll[k] = base && (ins[31:24] == 8'b1000_0011);
        assign is_sml[k]   = base && (ins[31:23] == 9'b1000011_00);
        assign is_cml[k]   = base && (ins[31:23] == 9'b1000011_01);
        assign is_sul[k]   = base && (ins[31:23] == 9'b1000011_10);
        assign is_cul[k]   = base && (ins[31:23] == 9'b1000011_11);
        assign is_jmp[k]   = is_ind_jump(ins, bus.commit_compressed_i[k]);
        assign lbl9[k]     = ins[23:15];
        assign lbl8[k]     = ins[22:15];
    end

    state_e                   st;
    logic [24:0]              lbl;
    logic                     handled;
    logic [NrCommitPorts-1:0] viol_v;
    viol_rec_t                viol_rec [NrCommitPorts];

    // Ports are walked in order so each one sees the state and label left by the ones before it.
    always_comb begin
        st      = state_q;
        lbl     = label_q;
        handled = 1'b0;
        viol_v  = '0;
        for (int k = 0; k < NrCommitPorts; k++) viol_rec[k] = '0;
        for (int k = 0; k < NrCommitPorts; k++) begin
            handled = 1'b0;
            if (bus.commit_valid_i[k]) begin
                viol_rec[k].pc = bus.commit_pc_i[k];
                if (enable_i && st == CHECKING) begin
                    if (is_cml[k]) begin
                        handled = 1'b1;
                        if (lbl8[k] != lbl[16:9]) begin
                            viol_v[k]         = 1'b1;
                            viol_rec[k].cause = 2'd2;
                            st                = IDLE;
                        end
                    end else if (is_cul[k]) begin
                        handled = 1'b1;
                        if (lbl8[k] != lbl[24:17]) begin
                            viol_v[k]         = 1'b1;
                            viol_rec[k].cause = 2'd3;
                            st                = IDLE;
                        end
                    end else begin
                        st = IDLE;
                    end
                end
                if (enable_i && st == EXPECT_LP) begin
                    handled   = 1'b1;
                    viol_v[k] = 1'b1;
                    if (is_jmp[k]) begin
                        viol_rec[k].cause = 2'd0;
                    end else if (is_lpcll[k] && lbl9[k] == lbl[8:0]) begin
                        viol_v[k] = 1'b0;
                        st        = CHECKING;
                    end else begin
                        viol_rec[k].cause = is_lpcll[k] ? 2'd1 : 2'd0;
                        st                = IDLE;
                    end
                end
                if (!handled) begin
                    if (enable_i && is_jmp[k]) st = EXPECT_LP;
                    else if (is_lpsll[k])      lbl = {16'd0, lbl9[k]};
                    else if (is_sml[k])        lbl[16:9] = lbl8[k];
                    else if (is_sul[k])        lbl[24:17] = lbl8[k];
                end
            end
        end
        state_d = (flush_i || !enable_i) ? IDLE : st;
        label_d = lbl;
    end

    logic pop;
    logic drop;
    int   free_slots;
    int   acc;

    // Multi-push queue: the same-cycle pop frees a slot, records beyond the free space are dropped.
    always_comb begin
        mem_d      = mem_q;
        pop        = (cnt_q != '0) && bus.viol_ready_i;
        free_slots = int'(ViolFifoDepth) - int'(cnt_q) + (pop ? 1 : 0);
        acc        = 0;
        drop       = 1'b0;
        for (int k = 0; k < NrCommitPorts; k++) begin
            if (viol_v[k]) begin
                if (acc < free_slots) begin
                    mem_d[wr_ptr_q + PW'(acc)] = viol_rec[k];
                    acc = acc + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        wr_ptr_d = wr_ptr_q + PW'(acc);
        rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        cnt_d    = CW'(int'(cnt_q) - (pop ? 1 : 0) + acc);
        ovf_d    = ovf_q | drop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            label_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < ViolFifoDepth; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            label_q  <= label_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < ViolFifoDepth; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign label_o          = label_q;
    assign viol_overflow_o  = ovf_q;
    assign bus.viol_valid_o = (cnt_q != '0);
    assign bus.viol_pc_o    = mem_q[rd_ptr_q].pc;
    assign bus.viol_cause_o = mem_q[rd_ptr_q].cause;
endmodule

// File: tb/tb_cfi_lp_checker.sv
// Directed bench for cfi_lp_checker: stimulus pushes expected violation records, a monitor pops and compares.
module tb_cfi_lp_checker;
    localparam int N  = 2;
    localparam int VL = 64;
    localparam int D  = 4;

    localparam logic [14:0] LpLow     = {3'b100, 5'd0, 7'b0010011};
    localparam logic [31:0] JALR_A0   = {12'd0, 5'd10, 3'b000, 5'd0, 7'b1100111};
    localparam logic [31:0] JALR_RA   = {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};
    localparam logic [31:0] JALR_LINK = {12'd0, 5'd11, 3'b000, 5'd1, 7'b1100111};
    localparam logic [31:0] ADDI      = {12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011};
    localparam logic [31:0] ADD       = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] CJALR_A1  = {16'd0, 3'b100, 1'b1, 5'd11, 5'd0, 2'b10};
    localparam logic [31:0] CJR_RA    = {16'd0, 3'b100, 1'b0, 5'd1, 5'd0, 2'b10};

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        flush_i;
    logic [24:0] label_o;
    logic        viol_overflow_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [65:0] exp_q[$];
    logic [65:0] mon_exp;

    cfi_lp_checker_if #(.NrCommitPorts(N), .VLEN(VL)) bus();

    cfi_lp_checker #(.NrCommitPorts(N), .VLEN(VL), .ViolFifoDepth(D)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .flush_i         (flush_i),
        .bus             (bus),
        .label_o         (label_o),
        .viol_overflow_o (viol_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] lpsll(input logic [8:0] l);
        return {8'b1000_0010, l, LpLow};
    endfunction
    function automatic logic [31:0] lpcll(input logic [8:0] l);
        return {8'b1000_0011, l, LpLow};
    endfunction
    function automatic logic [31:0] setter(input logic [1:0] sel, input logic [7:0] l);
        return {7'b1000011, sel, l, LpLow};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [63:0] pc, input logic [1:0] cause);
        exp_q.push_back({pc, cause});
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic commit1(input logic [31:0] ins, input logic [63:0] pc, input logic c = 1'b0);
        bus.commit_valid_i         = 2'b01;
        bus.commit_instr_i[0]      = ins;
        bus.commit_compressed_i[0] = c;
        bus.commit_pc_i[0]         = pc;
        cyc();
        bus.commit_valid_i = '0;
    endtask

    task automatic commit2(input logic [31:0] i0, input logic [63:0] p0, input logic c0,
                           input logic [31:0] i1, input logic [63:0] p1, input logic c1);
        bus.commit_valid_i         = 2'b11;
        bus.commit_instr_i[0]      = i0;
        bus.commit_compressed_i[0] = c0;
        bus.commit_pc_i[0]         = p0;
        bus.commit_instr_i[1]      = i1;
        bus.commit_compressed_i[1] = c1;
        bus.commit_pc_i[1]         = p1;
        cyc();
        bus.commit_valid_i = '0;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && bus.viol_valid_o && bus.viol_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got pc 0x%0h cause %0d, expected no record",
                         bus.viol_pc_o, bus.viol_cause_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("viol_record", 72'({bus.viol_pc_o, bus.viol_cause_o}), 72'(mon_exp));
            end
        end
    end

    initial begin
        rst_ni                  = 1'b0;
        enable_i                = 1'b1;
        flush_i                 = 1'b0;
        bus.viol_ready_i        = 1'b1;
        bus.commit_valid_i      = '0;
        bus.commit_instr_i      = '0;
        bus.commit_compressed_i = '0;
        bus.commit_pc_i         = '0;
        #12;
        chk("rst_label",      72'(label_o), 72'd0);
        chk("rst_viol_valid", 72'(bus.viol_valid_o), 72'd0);
        chk("rst_overflow",   72'(viol_overflow_o), 72'd0);
        chk("rst_viol_pc",    72'(bus.viol_pc_o), 72'd0);
        chk("rst_viol_cause", 72'(bus.viol_cause_o), 72'd0);
        rst_ni = 1'b1;
        cyc();

        // Clean jump/landing-pad sequence, then an LPCLL in IDLE is a no-op
        commit1(lpsll(9'h05A), 64'h100);
        commit1(JALR_A0, 64'h104);
        commit1(lpcll(9'h05A), 64'h300);
        commit1(ADDI, 64'h304);
        chk("label_lpsll", 72'(label_o), 72'h05A);
        commit1(lpcll(9'h1FF), 64'h308);

        // Missing landing pad, record visible only after the commit edge
        commit1(JALR_A0, 64'h8000_0010);
        exp_push(64'h8000_0100, 2'd0);
        bus.commit_valid_i         = 2'b01;
        bus.commit_instr_i[0]      = ADDI;
        bus.commit_compressed_i[0] = 1'b0;
        bus.commit_pc_i[0]         = 64'h8000_0100;
        #3;
        chk("no_same_cycle_record", 72'(bus.viol_valid_o), 72'd0);
        cyc();
        bus.commit_valid_i = '0;
        chk("record_next_cycle", 72'(bus.viol_valid_o), 72'd1);

        // Mid and upper label mismatches
        commit1(lpsll(9'h001), 64'h1F0);
        commit1(setter(2'b00, 8'h33), 64'h1F4);
        commit1(JALR_A0, 64'h1F8);
        commit1(lpcll(9'h001), 64'h1FC);
        exp_push(64'h200, 2'd2);
        commit1(setter(2'b01, 8'h34), 64'h200);
        chk("label_mid_kept", 72'(label_o), 72'h006601);
        commit1(setter(2'b10, 8'h7E), 64'h210);
        commit1(JALR_A0, 64'h214);
        commit1(lpcll(9'h001), 64'h218);
        commit1(setter(2'b01, 8'h33), 64'h21C);
        exp_push(64'h220, 2'd3);
        commit1(setter(2'b11, 8'h7F), 64'h220);
        chk("label_upper", 72'(label_o), 72'hFC6601);

        // Same-cycle jump and bad landing pad; returns are not checked
        exp_push(64'h402, 2'd1);
        commit2(CJALR_A1, 64'h400, 1'b1, lpcll(9'h0AA), 64'h402, 1'b0);
        commit1(JALR_RA, 64'h410);
        commit1(ADD, 64'h414);
        commit1(CJR_RA, 64'h418, 1'b1);
        commit1(ADD, 64'h41A);

        // Jump while expecting a pad, then a good pad
        commit1(JALR_A0, 64'h500);
        exp_push(64'h504, 2'd0);
        commit1(JALR_LINK, 64'h504);
        commit1(lpcll(9'h001), 64'h508);
        commit1(ADDI, 64'h50C);

        // A setter that violates leaves the label alone
        commit1(JALR_A0, 64'h600);
        exp_push(64'h604, 2'd0);
        commit1(lpsll(9'h0FF), 64'h604);
        chk("label_viol_setter", 72'(label_o), 72'hFC6601);

        // Disabled: no violations, setters still apply, pending expectation dropped
        enable_i = 1'b0;
        commit1(JALR_A0, 64'h700);
        commit1(ADDI, 64'h704);
        commit1(lpsll(9'h123), 64'h708);
        chk("label_disabled", 72'(label_o), 72'h123);
        enable_i = 1'b1;
        commit1(JALR_A0, 64'h720);
        enable_i = 1'b0;
        cyc();
        enable_i = 1'b1;
        commit1(ADDI, 64'h724);

        // Flush cancels the expectation raised in the same cycle
        flush_i = 1'b1;
        commit1(JALR_A0, 64'h710);
        flush_i = 1'b0;
        commit1(ADDI, 64'h714);

        // Overflow with the consumer stalled
        bus.viol_ready_i = 1'b0;
        exp_push(64'h1004, 2'd0);
        commit2(JALR_A0, 64'h1000, 1'b0, JALR_A0, 64'h1004, 1'b0);
        exp_push(64'h1008, 2'd0);
        exp_push(64'h100C, 2'd0);
        commit2(JALR_A0, 64'h1008, 1'b0, JALR_A0, 64'h100C, 1'b0);
        exp_push(64'h1010, 2'd0);
        commit2(JALR_A0, 64'h1010, 1'b0, JALR_A0, 64'h1014, 1'b0);
        commit2(JALR_A0, 64'h1018, 1'b0, JALR_A0, 64'h101C, 1'b0);
        chk("ovf_set", 72'(viol_overflow_o), 72'd1);
        chk("full_valid", 72'(bus.viol_valid_o), 72'd1);
        cyc();
        cyc();
        chk("head_pc_stable", 72'(bus.viol_pc_o), 72'h1004);
        chk("head_cause_stable", 72'(bus.viol_cause_o), 72'd0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        bus.viol_ready_i = 1'b1;
        repeat (6) cyc();
        chk("drained", 72'(bus.viol_valid_o), 72'd0);
        chk("ovf_sticky", 72'(viol_overflow_o), 72'd1);

        // Reset while expecting a pad with three records queued
        bus.viol_ready_i = 1'b0;
        commit2(JALR_A0, 64'h2000, 1'b0, JALR_A0, 64'h2004, 1'b0);
        commit2(JALR_A0, 64'h2008, 1'b0, JALR_A0, 64'h200C, 1'b0);
        chk("three_queued", 72'(bus.viol_valid_o), 72'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 72'(bus.viol_valid_o), 72'd0);
        chk("arst_label", 72'(label_o), 72'd0);
        chk("arst_overflow", 72'(viol_overflow_o), 72'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus.viol_ready_i = 1'b1;
        cyc();
        commit1(ADDI, 64'h3000);
        repeat (3) cyc();
        chk("post_reset_valid", 72'(bus.viol_valid_o), 72'd0);
        chk("post_reset_label", 72'(label_o), 72'd0);

        repeat (2) cyc();
        chk("scoreboard_left", 72'(exp_q.size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
